// File: rtl/shift_rx_ctrl.sv
// Serial receiver: start/4 data bits (LSB first)/stop, mid-bit sampling, valid/ready output.
// Define SHIFT_RX_PARITY_EN to add an even-parity bit between data bit 3 and the stop bit.
module shift_rx_ctrl #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic [3:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(BIT_CYCLES / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef SHIFT_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_next;
    logic [3:0]      shift_q, shift_d;
    logic [1:0]      bit_idx_q, bit_idx_d;
    logic [3:0]      out_d;
    logic            out_valid_d, frame_err_d, overrun_d;
    logic            load, bad, par_ok;

`ifdef SHIFT_RX_PARITY_EN
    logic par_err_q, par_err_d;
    assign par_ok = ~par_err_q;
`else
    assign par_ok = 1'b1;
`endif

    assign cnt_next = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    assign busy     = (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_next;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        load      = 1'b0;
        bad       = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!in) state_d = StStart;
            end
            StStart: begin
                // Mid-start-bit recheck filters glitches shorter than half a bit
                if (cnt_q == HalfCnt) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = in ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == LastCnt) begin
                    shift_d   = {in, shift_q[3:1]};
                    bit_idx_d = bit_idx_q + 2'd1;
                    if (bit_idx_q == 2'd3) begin
                        cnt_d = '0;
`ifdef SHIFT_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef SHIFT_RX_PARITY_EN
            StParity: begin
                if (cnt_q == LastCnt) begin
                    par_err_d = in ^ (^shift_q);
                    cnt_d     = '0;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (in && par_ok) load = 1'b1;
                    else              bad  = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        out_d       = out;
        out_valid_d = out_valid;
        frame_err_d = bad;
        overrun_d   = 1'b0;
        if (out_valid && out_ready) out_valid_d = 1'b0;
        // A word arriving while the old one is still unconsumed is dropped
        if (load) begin
            if (out_valid && !out_ready) begin
                overrun_d = 1'b1;
            end else begin
                out_d       = shift_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
`ifdef SHIFT_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

endmodule
